// File: rtl/imem_fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// IMEM_FETCH_HALT_EN adds the HALTED state to fetch_state_t.
package imem_fetch_pkg;

    localparam int unsigned DefaultN     = 32;
    localparam int unsigned DefaultAw    = 6;
    localparam int unsigned DefaultDepth = 4;

    // ROM padding word; stops fetch when the halt feature is built in.
    localparam logic [DefaultN-1:0] HaltWord = 32'h0;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
`ifdef IMEM_FETCH_HALT_EN
        StDrain,
        StHalted
`else
        StDrain
`endif
    } fetch_state_t;

    typedef struct packed {
        logic [DefaultAw-1:0] pc;
        logic [DefaultN-1:0]  instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, instr} entries; flush clears it and wins over push/pop.
module fetch_fifo
    import imem_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = DefaultDepth
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  fetch_entry_t             din_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o,
    output fetch_entry_t             head_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [PtrW-1:0] rd_q, wr_q;
    logic [CntW-1:0] cnt_q;
    fetch_entry_t    mem_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + PtrW'(1);
            if (pop_i)  rd_q <= rd_q + PtrW'(1);
            cnt_q <= cnt_q + CntW'(push_i) - CntW'(pop_i);
        end
    end

    // Storage carries no reset; empty entries are masked by the consumer.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) mem_q[wr_q] <= din_i;
    end

    assign count_o = cnt_q;
    assign full_o  = (cnt_q == CntW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_q];

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: walks the ROM into a prefetch FIFO, handles redirects.
// Build with IMEM_FETCH_HALT_EN to stop fetching at the all-zero padding word.
module imem_fetch_ctrl
    import imem_fetch_pkg::*;
#(
    parameter int unsigned N     = DefaultN,
    parameter int unsigned AW    = DefaultAw,
    parameter int unsigned DEPTH = DefaultDepth
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          fetch_en_i,
    output logic [AW-1:0] imem_addr_o,
    input  logic [N-1:0]  imem_q_i,
    input  logic          redirect_valid_i,
    input  logic [AW-1:0] redirect_addr_i,
    output logic          instr_valid_o,
    input  logic          instr_ready_i,
    output logic [N-1:0]  instr_data_o,
    output logic [AW-1:0] instr_pc_o,
    output logic          busy_o
);

    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    fetch_state_t    state_q, state_d;
    logic [AW-1:0]   fetch_pc_q, fetch_pc_d;
    logic            push, pop, flush, can_push, redirect;
    logic            fifo_full, fifo_empty;
    logic [CntW-1:0] fifo_cnt;
    fetch_entry_t    push_entry, head;

    assign pop        = instr_valid_o && instr_ready_i;
    assign can_push   = !fifo_full || pop;
    assign redirect   = redirect_valid_i && (state_q != StIdle);
    assign push_entry = '{pc: fetch_pc_q, instr: imem_q_i};

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        push       = 1'b0;
        flush      = 1'b0;
        if (redirect) begin
            flush      = 1'b1;
            fetch_pc_d = redirect_addr_i;
            state_d    = fetch_en_i ? StFetch : StDrain;
`ifdef IMEM_FETCH_HALT_EN
            if (state_q == StHalted) state_d = StFetch;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (fetch_en_i) state_d = StFetch;
                end
                StFetch: begin
                    if (!fetch_en_i) begin
                        state_d = StDrain;
                    end else if (can_push) begin
`ifdef IMEM_FETCH_HALT_EN
                        if (imem_q_i == HaltWord) begin
                            state_d = StHalted;
                        end else begin
                            push       = 1'b1;
                            fetch_pc_d = fetch_pc_q + AW'(1);
                        end
`else
                        push       = 1'b1;
                        fetch_pc_d = fetch_pc_q + AW'(1);
`endif
                    end
                end
                StDrain: begin
                    if (fetch_en_i)      state_d = StFetch;
                    else if (fifo_empty) state_d = StIdle;
                end
`ifdef IMEM_FETCH_HALT_EN
                StHalted: begin
                    // Only a redirect or reset leaves HALTED.
                    state_d = StHalted;
                end
`endif
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            fetch_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .din_i   (push_entry),
        .count_o (fifo_cnt),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (head)
    );

    assign imem_addr_o   = fetch_pc_q;
    assign instr_valid_o = !fifo_empty;
    assign instr_data_o  = fifo_empty ? '0 : head.instr;
    assign instr_pc_o    = fifo_empty ? '0 : head.pc;

`ifdef IMEM_FETCH_HALT_EN
    assign busy_o = ((state_q != StIdle) && (state_q != StHalted)) || !fifo_empty;
`else
    assign busy_o = (state_q != StIdle) || !fifo_empty;
`endif

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
- Instruction-fetch sequencer that owns the address port of the 64-word instruction ROM (`imem`: 6-bit word address, 32-bit word, combinational read).
- Keeps a fetch PC and reads one word per cycle into a small prefetch FIFO.
- Presents instructions to decode through a valid/ready handshake.
- Handles branch redirects by flushing the FIFO and restarting at the target.

Parameters:
- N, 32: instruction width; must match `imem` N.
- AW, 6: word-address width; ROM depth = 2**AW.
- DEPTH, 4: prefetch FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- fetch_en  in  1  run request from core control.
- imem_addr  out  AW  address to `imem.addr`; driven directly from the fetch_pc register.
- imem_q  in  N  read data from `imem.q`; valid in the same cycle.
- redirect_valid  in  1  branch taken; single-cycle pulse or level.
- redirect_addr  in  AW  word address of the branch target.
- instr_valid  out  1  FIFO head holds a valid instruction.
- instr_ready  in  1  decode accepts the head this cycle.
- instr_data  out  N  instruction at the FIFO head; 0 when the FIFO is empty.
- instr_pc  out  AW  word address of instr_data; 0 when the FIFO is empty.
- busy  out  1  state is not IDLE, or the FIFO is not empty.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - fetch_pc=0, count=0, head/tail pointers=0, state=IDLE.
  - Outputs: imem_addr=0, instr_valid=0, instr_data=0, instr_pc=0, busy=0.
- Definitions:
  - pop = instr_valid && instr_ready.
  - can_push = (count < DEPTH) || pop.
- State machine:
  - IDLE: no fetch. Go to FETCH when fetch_en=1.
  - FETCH: when can_push, push {fetch_pc, imem_q} and set fetch_pc <= fetch_pc+1.
    - Address wraps modulo 2**AW (63 -> 0).
    - When the FIFO is full and there is no pop, hold fetch_pc; nothing is pushed.
    - When fetch_en=0, go to DRAIN; no push in that cycle.
  - DRAIN: no push; the FIFO keeps popping. Go to IDLE when count reaches 0, or to FETCH when fetch_en=1 again.
- Redirect (any state except IDLE; ignored in IDLE):
  - Takes priority over push, state change and pop bookkeeping.
  - At the edge: count=0, pointers cleared, fetch_pc=redirect_addr, state=FETCH, or DRAIN if fetch_en=0.
  - An instr_valid && instr_ready transfer in the redirect cycle counts as completed; discarding it is decode's job.
- Latency:
  - Redirect sampled at edge k: imem_addr=redirect_addr during cycle k..k+1, and the first pushed entry is visible as instr_valid=1 after edge k+1.
  - Without redirects, one instruction per cycle is sustained when instr_ready is held at 1.
- Push and pop in the same cycle: allowed at full and at empty; count is unchanged when full.
- Back-to-back redirects: the last one wins; every redirect restarts the latency.
- Reset asserted mid-operation: everything returns to reset values immediately, without waiting for a clock.

Optional Feature:
- Macro: IMEM_FETCH_HALT_EN.
- Defined:
  - Adds state HALTED.
  - In FETCH, a fetched imem_q == 0 (the ROM padding word) is not pushed; fetch_pc holds and state goes to HALTED.
  - HALTED: no fetch, FIFO drains, busy=1 until empty. Leave HALTED only by redirect (to FETCH) or reset; fetch_en is ignored.
- Undefined: all-zero words are ordinary instructions and the HALTED state does not exist.

Decomposition:
- Package imem_fetch_pkg:
  - State enum fetch_state_t (IDLE, FETCH, DRAIN, HALTED under the macro).
  - Entry struct fetch_entry_t {pc[AW-1:0], instr[N-1:0]}.
  - Constants: default AW, DEPTH and the halt word (32'h0).
- One sub-module, fetch_fifo: synchronous FIFO of fetch_entry_t.
  - Inputs: push, pop, flush.
  - Outputs: count, full, empty, head.
  - Asynchronous active-low reset.

Test Plan:
- Reset release, fetch_en=1, instr_ready=1, ROM holds cb170018, b4000098, f8000000, 8b010000, 17fffffc:
  - First instr_valid after the second edge, with instr_pc=0 and data=cb170018.
  - pc 0..4 then follow on consecutive cycles.
- instr_ready=0 for 10 cycles:
  - count saturates at 4 and imem_addr holds at 4.
  - On release, pcs 0,1,2,3,4 come out in order with no gap and no duplicate.
- Redirect to addr 2 while the FIFO holds pcs 5..8 and pop=1:
  - After the next edge count=0 and imem_addr=2.
  - Next instr_valid shows pc=2, data=f8000000.
- fetch_pc=63, free-running:
  - Sequence of instr_pc is 63, 0, 1.
- fetch_en dropped with 3 entries buffered:
  - The 3 entries drain, then IDLE with busy=0 and no further imem_addr change.
- Reset pulsed mid-stream:
  - Outputs go to 0 immediately.
  - With IMEM_FETCH_HALT_EN: pc 5 (word 0) is never presented, state is HALTED, and a redirect to 0 restarts fetch.
